// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch unit with a prefetch queue.
//
// Keeps at most one request outstanding to instruction memory. Returned words
// are pushed with their addresses into a FIFO of DEPTH entries. The head of
// that FIFO is presented to the data path. A redirect flushes the queue and
// restarts fetching at the new target. If a request is still in flight when
// the redirect arrives, its response is dropped first.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request; held stable until imem_ack
//   imem_ack/imem_rdata request accepted, data valid in the same cycle
//   redirect/redirect_pc restart fetch at {redirect_pc[31:2],2'b00}
//   stall               the data path cannot consume this cycle
//   instr/instr_pc/instr_valid  head of the queue; consumed when valid && !stall
// Build option:
//   FETCH_BYPASS_EN  an ack that arrives while the queue is empty and not
//                    stalled is presented in the same cycle and not queued
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   pend_q;
  logic [31:0]   last_instr;
  logic [31:0]   last_pc;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [31:0]   tgt;
  logic          q_empty;
  logic          ack_req;
  logic          bypass;
  logic          push;
  logic          pop;

  assign tgt     = {redirect_pc[31:2], 2'b00};
  assign q_empty = (count == '0);
  assign ack_req = (state == REQ) && imem_ack;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_req && q_empty && !stall && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // Redirect overrides both queue operations in the same cycle.
  assign push = ack_req && !redirect && !bypass;
  assign pop  = !q_empty && !stall && !redirect;

  always_comb begin
    count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = addr_q;

  // While the queue is empty, the last presented word is shown again.
  always_comb begin
    instr_valid = !q_empty || bypass;
    instr       = q_empty ? last_instr : mem_instr[rd_ptr];
    instr_pc    = q_empty ? last_pc    : mem_pc[rd_ptr];
    if (bypass) begin
      instr    = imem_rdata;
      instr_pc = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= RESET_PC;
      pend_q     <= '0;
      last_instr <= '0;
      last_pc    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      // Track whatever is currently presented so that it can be held once the
      // queue drains or is flushed.
      if (bypass) begin
        last_instr <= imem_rdata;
        last_pc    <= addr_q;
      end else if (!q_empty) begin
        last_instr <= mem_instr[rd_ptr];
        last_pc    <= mem_pc[rd_ptr];
      end

      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        case (state)
          IDLE: begin
            state  <= REQ;
            addr_q <= tgt;
          end
          REQ: begin
            if (imem_ack) begin
              state  <= REQ;
              addr_q <= tgt;
            end else begin
              // Request still in flight: keep it stable and discard its data.
              state  <= DROP;
              pend_q <= tgt;
            end
          end
          DROP: begin
            if (imem_ack) begin
              state  <= REQ;
              addr_q <= tgt;
            end else begin
              pend_q <= tgt;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        count <= count_nxt;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case (state)
          IDLE: begin
            if (count_nxt < DEPTH_C) state <= REQ;
          end
          REQ: begin
            if (imem_ack) begin
              addr_q <= addr_q + 32'd4;
              state  <= (count_nxt < DEPTH_C) ? REQ : IDLE;
            end
          end
          DROP: begin
            if (imem_ack) begin
              state  <= REQ;
              addr_q <= pend_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int unsigned total;
  int unsigned passed;

  // Memory model: every word is its own address xor KEY.
  assign imem_rdata = imem_addr ^ KEY;

  instr_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic outs(input string tag, input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ep);
    chk({tag, " req"},   {31'b0, imem_req},    {31'b0, er});
    chk({tag, " addr"},  imem_addr,            ea);
    chk({tag, " valid"}, {31'b0, instr_valid}, {31'b0, ev});
    chk({tag, " pc"},    instr_pc,             ep);
    if (ev) chk({tag, " instr"}, instr, ep ^ KEY);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] p);
    @(negedge clk);
    imem_ack    = a;
    stall       = s;
    redirect    = r;
    redirect_pc = p;
    #1;
  endtask

  task automatic reset_release;
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  logic [31:0] exp_pcs [5];

  initial begin
    total = 0; passed = 0;
    reset = 1'b0; imem_ack = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset values while reset is held, even with ack asserted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst req",   {31'b0, imem_req},    32'd0);
    chk("rst addr",  imem_addr,            32'h0);
    chk("rst valid", {31'b0, instr_valid}, 32'd0);
    chk("rst instr", instr,                32'h0);
    chk("rst pc",    instr_pc,             32'h0);

    // Streaming, one stall cycle, redirect coinciding with ack and pop.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0200, 1'b0, 32'h0000_000C};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0200, 1'b0, 32'h0000_000C};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200};

    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0;
    #1;
    chk("rel req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ack, tbl[i].stl, tbl[i].rdr, tbl[i].rpc);
      outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
    end

    // Full queue under stall: fetch stops at 0x10, then drains in order.
    reset_release();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    outs("full", 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0000);
    exp_pcs[0] = 32'h0; exp_pcs[1] = 32'h4; exp_pcs[2] = 32'h8;
    exp_pcs[3] = 32'hC; exp_pcs[4] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk($sformatf("drain%0d valid", i), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("drain%0d pc", i), instr_pc, exp_pcs[i]);
      if (i == 1) begin
        chk("resume req",  {31'b0, imem_req}, 32'd1);
        chk("resume addr", imem_addr,         32'h0000_0010);
      end
    end

    // Redirect while a slow request is outstanding: response dropped.
    reset_release();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("slow c1", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    outs("slow c2", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("drop c3", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("drop c4", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("tgt c5", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("tgt c6", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("tgt c7", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("tgt c8", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);

    // A second redirect during the drop replaces the pending target.
    reset_release();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0402);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("redrop ack", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("redrop tgt", 1'b1, 32'h0000_0400, 1'b0, 32'h0);

    // Address wrap at the top of the address space.
    reset_release();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    outs("wrap c1", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap c2", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap c3", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap c4", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("wrap c5", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("wrap c6", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);

    // Reset asserted with a request outstanding; acks during reset are ignored.
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1;
    #1;
    outs("midrst a", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("midrst a instr", instr, 32'h0);
    @(negedge clk);
    #1;
    outs("midrst b", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0;
    #1;
    chk("restart idle", {31'b0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    outs("restart req", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    outs("restart out", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
